// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: FSM state enum, statistics counter width, round-robin pointer wrap.
package adder_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int STAT_W = 8;

  // Pointer to the requester after `id`, wrapping modulo n.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant for the first active request at or after ptr.
// Latency: purely combinational.
// Backpressure: none; gnt is all-zero when no request is active.
// Ports:
//   req    in  NUM_REQ          active requests
//   ptr    in  $clog2(NUM_REQ)  highest-priority index for this search
//   gnt    out NUM_REQ          one-hot grant (zero if no request)
//   gnt_id out $clog2(NUM_REQ)  index of the granted request (0 if none)
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    // Walk NUM_REQ positions starting at ptr; the first active one wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Time-shares one external combinational adder among NUM_REQ requesters, round-robin.
// Latency: grant edge N -> sum captured and rsp_valid high after edge N+1 (one EXEC cycle).
// Backpressure: response held until rsp_ready; no new grant is issued while a response is pending.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester handshake (req_ready one-hot, only in IDLE)
//   req_a/req_b                packed operands, requester i at [i*DATA_W +: DATA_W]
//   add_a/add_b/add_sum        to/from the shared adder
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_sum             owner id and registered DATA_W+1 bit sum
// Optional (ADDER_SHARE_ARB_STATS_EN): grant_cnt (8 bits per requester), carry_cnt,
// both saturating at 255.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W:0]           add_sum,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W:0]           rsp_sum
`ifdef ADDER_SHARE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]         carry_cnt
`endif
);

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cur_id;
  logic                grant_fire;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign grant_fire = (state == ST_IDLE) && (|req_valid);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: the arbiter result is only exposed while idle.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE) req_ready = gnt;
  end

  // Operand capture, pointer update and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a     <= '0;
      add_b     <= '0;
      cur_id    <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else begin
      if (grant_fire) begin
        add_a  <= req_a[int'(gnt_id)*DATA_W +: DATA_W];
        add_b  <= req_b[int'(gnt_id)*DATA_W +: DATA_W];
        cur_id <= gnt_id;
        rr_ptr <= ID_W'(rr_next(int'(gnt_id), NUM_REQ));
      end
      // The adder is combinational: add_sum is already valid in EXEC.
      if (state == ST_EXEC) begin
        rsp_sum   <= add_sum;
        rsp_id    <= cur_id;
        rsp_valid <= 1'b1;
      end
      if (state == ST_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef ADDER_SHARE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      carry_cnt <= '0;
    end else begin
      if (grant_fire && (grant_cnt[int'(gnt_id)*STAT_W +: STAT_W] != {STAT_W{1'b1}}))
        grant_cnt[int'(gnt_id)*STAT_W +: STAT_W] <=
          grant_cnt[int'(gnt_id)*STAT_W +: STAT_W] + STAT_W'(1);
      if ((state == ST_EXEC) && add_sum[DATA_W] && (carry_cnt != {STAT_W{1'b1}}))
        carry_cnt <= carry_cnt + STAT_W'(1);
    end
  end
`endif

endmodule
